// File: rtl/id_ex_stage.sv
// ID->EX pipeline register: operand select, EX/MEM and MEM/WB forwarding, load-use bubble, flush.
// Optional perf counters are enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage #(
    parameter int XLEN = 64,
    parameter int REGW = 5,
    parameter int OPW  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [REGW-1:0] in_rs1,
    input  logic [REGW-1:0] in_rs2,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_use_imm,
    input  logic [OPW-1:0]  in_alu_op,
    input  logic [REGW-1:0] in_rd,
    input  logic [3:0]      in_ctl,
    input  logic            flush,
    input  logic            exm_wr,
    input  logic [REGW-1:0] exm_rd,
    input  logic [XLEN-1:0] exm_data,
    input  logic            mwb_wr,
    input  logic [REGW-1:0] mwb_rd,
    input  logic [XLEN-1:0] mwb_data,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [XLEN-1:0] alu_op1,
    output logic [XLEN-1:0] alu_op2,
    output logic [OPW-1:0]  alu_operand,
    output logic [XLEN-1:0] store_data,
    output logic [REGW-1:0] out_rd,
    output logic [3:0]      out_ctl,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     flush_cnt
);

    logic [REGW-1:0] rs1_q, rs2_q;
    logic [XLEN-1:0] rs1_val, rs2_val, imm_q;
    logic            use_imm_q;
    logic            hazard, held_stall, in_fire;
    logic [XLEN-1:0] fwd1, fwd2;

    // out_ctl[2] is mem_read: a held load cannot supply its result to the next instruction
    assign hazard = in_valid & out_valid & out_ctl[2] & (out_rd != '0) &
                    ((in_rs1 == out_rd) | (in_rs2 == out_rd));
    assign held_stall = out_valid & ~out_ready;
    assign in_ready   = flush | (~hazard & (~out_valid | out_ready));
    assign in_fire    = in_valid & in_ready;

    always_comb begin
        fwd1 = rs1_val;
        fwd2 = rs2_val;
        if (exm_wr && exm_rd == rs1_q && rs1_q != '0)
            fwd1 = exm_data;
        else if (mwb_wr && mwb_rd == rs1_q && rs1_q != '0)
            fwd1 = mwb_data;
        if (exm_wr && exm_rd == rs2_q && rs2_q != '0)
            fwd2 = exm_data;
        else if (mwb_wr && mwb_rd == rs2_q && rs2_q != '0)
            fwd2 = mwb_data;
    end

    assign alu_op1    = fwd1;
    assign store_data = fwd2;
    assign alu_op2    = use_imm_q ? imm_q : fwd2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rs1_val     <= '0;
            rs2_val     <= '0;
            imm_q       <= '0;
            use_imm_q   <= 1'b0;
            alu_operand <= '0;
            out_rd      <= '0;
            out_ctl     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_fire) begin
            out_valid   <= 1'b1;
            rs1_q       <= in_rs1;
            rs2_q       <= in_rs2;
            rs1_val     <= in_rs1_data;
            rs2_val     <= in_rs2_data;
            imm_q       <= in_imm;
            use_imm_q   <= in_use_imm;
            alu_operand <= in_alu_op;
            out_rd      <= in_rd;
            out_ctl     <= in_ctl;
        end else if (held_stall) begin
            // capture forwarded data so it survives the producer leaving the pipe
            rs1_val <= fwd1;
            rs2_val <= fwd2;
        end else begin
            out_valid <= 1'b0;
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (hazard | held_stall)
                stall_cnt <= stall_cnt + 32'd1;
            if (flush & out_valid)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a behavioural model checked every cycle plus literal spot checks.
module tb_id_ex_stage;
    localparam int XLEN = 64;
    localparam int REGW = 5;
    localparam int OPW  = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid, in_ready;
    logic [REGW-1:0] in_rs1, in_rs2, in_rd;
    logic [XLEN-1:0] in_rs1_data, in_rs2_data, in_imm;
    logic            in_use_imm;
    logic [OPW-1:0]  in_alu_op;
    logic [3:0]      in_ctl;
    logic            flush;
    logic            exm_wr, mwb_wr;
    logic [REGW-1:0] exm_rd, mwb_rd;
    logic [XLEN-1:0] exm_data, mwb_data;
    logic            out_ready, out_valid;
    logic [XLEN-1:0] alu_op1, alu_op2, store_data;
    logic [OPW-1:0]  alu_operand;
    logic [REGW-1:0] out_rd;
    logic [3:0]      out_ctl;
    logic [31:0]     stall_cnt, flush_cnt;

    int compared   = 0;
    int mismatched = 0;
    bit done       = 1'b0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .REGW(REGW), .OPW(OPW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_imm(in_imm), .in_use_imm(in_use_imm), .in_alu_op(in_alu_op),
        .in_rd(in_rd), .in_ctl(in_ctl), .flush(flush),
        .exm_wr(exm_wr), .exm_rd(exm_rd), .exm_data(exm_data),
        .mwb_wr(mwb_wr), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
        .out_ready(out_ready), .out_valid(out_valid),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_operand(alu_operand),
        .store_data(store_data), .out_rd(out_rd), .out_ctl(out_ctl),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Model: the instruction currently held by the stage, plus counters
    typedef struct {
        logic        v;
        logic [4:0]  rs1, rs2, rd;
        logic [63:0] d1, d2, imm;
        logic        ui;
        logic [3:0]  op, ctl;
    } held_t;

    held_t       m;
    int unsigned m_stall, m_flush;

    function automatic logic [63:0] fwd(input logic [4:0] s, input logic [63:0] held);
        if (s == 5'd0) return held;
        if (exm_wr && exm_rd == s) return exm_data;
        if (mwb_wr && mwb_rd == s) return mwb_data;
        return held;
    endfunction

    function automatic logic needs_pending_load();
        return in_valid && m.v && m.ctl[2] && m.rd != 5'd0 &&
               (in_rs1 == m.rd || in_rs2 == m.rd);
    endfunction

    function automatic logic model_ready();
        if (flush) return 1'b1;
        return !needs_pending_load() && !(m.v && !out_ready);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m.v = 0; m.rs1 = 0; m.rs2 = 0; m.rd = 0; m.d1 = 0; m.d2 = 0;
            m.imm = 0; m.ui = 0; m.op = 0; m.ctl = 0;
            m_stall = 0; m_flush = 0;
        end else begin
            logic dep, busy;
            dep  = needs_pending_load();
            busy = m.v && !out_ready;
            if (dep || busy) m_stall++;
            if (flush && m.v) m_flush++;
            if (flush) begin
                m.v = 0;
            end else if (in_valid && !dep && !busy) begin
                m.v = 1; m.rs1 = in_rs1; m.rs2 = in_rs2; m.rd = in_rd;
                m.d1 = in_rs1_data; m.d2 = in_rs2_data; m.imm = in_imm;
                m.ui = in_use_imm; m.op = in_alu_op; m.ctl = in_ctl;
            end else if (busy) begin
                m.d1 = fwd(m.rs1, m.d1);
                m.d2 = fwd(m.rs2, m.d2);
            end else begin
                m.v = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!done) begin
            logic [63:0] e_st;
            logic [31:0] e_sc, e_fc;
            e_st = fwd(m.rs2, m.d2);
`ifdef ID_EX_PERF_CNT_EN
            e_sc = m_stall;
            e_fc = m_flush;
`else
            e_sc = 32'd0;
            e_fc = 32'd0;
`endif
            chk("out_valid", 64'(out_valid), 64'(m.v));
            chk("in_ready", 64'(in_ready), 64'(model_ready()));
            chk("alu_op1", alu_op1, fwd(m.rs1, m.d1));
            chk("store_data", store_data, e_st);
            chk("alu_op2", alu_op2, m.ui ? m.imm : e_st);
            chk("alu_operand", 64'(alu_operand), 64'(m.op));
            chk("out_rd", 64'(out_rd), 64'(m.rd));
            chk("out_ctl", 64'(out_ctl), 64'(m.ctl));
            chk("stall_cnt", 64'(stall_cnt), 64'(e_sc));
            chk("flush_cnt", 64'(flush_cnt), 64'(e_fc));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rs1_data = 0; in_rs2_data = 0;
        in_imm = 0; in_use_imm = 0; in_alu_op = 0; in_rd = 0; in_ctl = 0;
        flush = 0; exm_wr = 0; exm_rd = 0; exm_data = 0;
        mwb_wr = 0; mwb_rd = 0; mwb_data = 0;
    endtask

    task automatic send(input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [63:0] d1, input logic [63:0] d2,
                        input logic [63:0] imm, input logic ui,
                        input logic [3:0] op, input logic [4:0] rd, input logic [3:0] ctl);
        in_valid = 1; in_rs1 = rs1; in_rs2 = rs2; in_rs1_data = d1; in_rs2_data = d2;
        in_imm = imm; in_use_imm = ui; in_alu_op = op; in_rd = rd; in_ctl = ctl;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        out_ready = 1;
        #1 rst = 1;
        @(posedge clk);
        tick();
        rst = 0;
        chk("lit_reset_valid", 64'(out_valid), 64'd0);

        // add x3 = x1 + x2
        send(5'd1, 5'd2, 64'd5, 64'd7, 64'd0, 1'b0, 4'b0000, 5'd3, 4'b1000);
        #1 chk("lit_add_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 0;
        #1;
        chk("lit_add_valid", 64'(out_valid), 64'd1);
        chk("lit_add_op1", alu_op1, 64'd5);
        chk("lit_add_op2", alu_op2, 64'd7);
        chk("lit_add_operand", 64'(alu_operand), 64'd0);
        tick();

        // forwarding priority on a held instruction, stage stalled
        out_ready = 0;
        send(5'd4, 5'd0, 64'h11, 64'd0, 64'd0, 1'b0, 4'b0010, 5'd5, 4'b1000);
        tick();
        in_valid = 0;
        exm_wr = 1; exm_rd = 5'd4; exm_data = 64'hAA;
        mwb_wr = 1; mwb_rd = 5'd4; mwb_data = 64'hBB;
        #1 chk("lit_fwd_exm", alu_op1, 64'hAA);
        exm_wr = 0;
        #1 chk("lit_fwd_mwb", alu_op1, 64'hBB);
        mwb_wr = 0;
        flush = 1;
        tick();
        flush = 0;
        send(5'd0, 5'd0, 64'h33, 64'h44, 64'd0, 1'b0, 4'b0001, 5'd9, 4'b1000);
        tick();
        in_valid = 0;
        exm_wr = 1; exm_rd = 5'd0; exm_data = 64'hAA;
        mwb_wr = 1; mwb_rd = 5'd0; mwb_data = 64'hBB;
        #1;
        chk("lit_x0_op1", alu_op1, 64'h33);
        chk("lit_x0_store", store_data, 64'h44);
        exm_wr = 0; mwb_wr = 0;
        flush = 1;
        tick();
        flush = 0;
        out_ready = 1;

        // load-use: held load to x6, next instruction reads x6
        send(5'd1, 5'd0, 64'h10, 64'd0, 64'd8, 1'b1, 4'b0000, 5'd6, 4'b1100);
        tick();
        send(5'd3, 5'd6, 64'h20, 64'd0, 64'd0, 1'b0, 4'b0001, 5'd7, 4'b1000);
        #1 chk("lit_hazard_ready", 64'(in_ready), 64'd0);
        tick();
        #1;
        chk("lit_bubble_valid", 64'(out_valid), 64'd0);
        chk("lit_bubble_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 0;
        mwb_wr = 1; mwb_rd = 5'd6; mwb_data = 64'hDEAD;
        #1;
        chk("lit_lu_valid", 64'(out_valid), 64'd1);
        chk("lit_lu_op1", alu_op1, 64'h20);
        chk("lit_lu_store", store_data, 64'hDEAD);
        chk("lit_lu_op2", alu_op2, 64'hDEAD);
        mwb_wr = 0;
        tick();

        // forwarded value captured during a 3-cycle stall
        send(5'd9, 5'd0, 64'h1, 64'd0, 64'd0, 1'b0, 4'b0000, 5'd10, 4'b1000);
        tick();
        in_valid = 0;
        out_ready = 0;
        mwb_wr = 1; mwb_rd = 5'd9; mwb_data = 64'h55;
        tick();
        mwb_wr = 0;
        tick();
        tick();
        out_ready = 1;
        #1;
        chk("lit_stall_valid", 64'(out_valid), 64'd1);
        chk("lit_stall_op1", alu_op1, 64'h55);
        tick();

        // asynchronous reset while an instruction is held and another is offered
        send(5'd1, 5'd2, 64'd3, 64'd4, 64'd0, 1'b0, 4'b0110, 5'd5, 4'b1000);
        tick();
        send(5'd1, 5'd2, 64'd3, 64'd4, 64'd0, 1'b0, 4'b0101, 5'd5, 4'b1000);
        #2 rst = 1;
        #1;
        chk("lit_rst_valid", 64'(out_valid), 64'd0);
        chk("lit_rst_operand", 64'(alu_operand), 64'd0);
        chk("lit_rst_rd", 64'(out_rd), 64'd0);
        chk("lit_rst_stall_cnt", 64'(stall_cnt), 64'd0);
        chk("lit_rst_flush_cnt", 64'(flush_cnt), 64'd0);
        in_valid = 0;
        tick();
        rst = 0;

        // flush during a stall drops both held and incoming instructions
        send(5'd2, 5'd0, 64'h7, 64'd0, 64'd0, 1'b0, 4'b0000, 5'd8, 4'b1000);
        tick();
        in_valid = 0;
        out_ready = 0;
        tick();
        send(5'd1, 5'd0, 64'h99, 64'd0, 64'd0, 1'b0, 4'b0011, 5'd11, 4'b1000);
        flush = 1;
        #1 chk("lit_flush_ready", 64'(in_ready), 64'd1);
        tick();
        flush = 0;
        in_valid = 0;
        #1;
        chk("lit_flush_valid", 64'(out_valid), 64'd0);
        chk("lit_flush_op1_held", alu_op1, 64'h7);
        chk("lit_flush_rd_held", 64'(out_rd), 64'd8);
`ifdef ID_EX_PERF_CNT_EN
        chk("lit_flush_cnt", 64'(flush_cnt), 64'd1);
        chk("lit_stall_cnt", 64'(stall_cnt), 64'd2);
`else
        chk("lit_flush_cnt_off", 64'(flush_cnt), 64'd0);
        chk("lit_stall_cnt_off", 64'(stall_cnt), 64'd0);
`endif
        out_ready = 1;
        tick();
        tick();
        done = 1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
